// File: rtl/pb_spi_slave.sv
// pb_spi_slave: PicoBlaze port-mapped SPI responder (mode 0, MSB first, 8-bit frames).
// Registers at BASE_ADDRESS+0..3: DATA, STATUS, CTRL, CLEAR.
// Optional build macro PB_SPI_SLAVE_MISO_TRISTATE_EN: miso_o becomes an inout that is
// driven only while a frame is active and high-Z otherwise.
`timescale 1ns/1ps
module pb_spi_slave #(
  parameter logic [7:0] BASE_ADDRESS = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] data_in,
  input  logic       read_strobe,
  input  logic       write_strobe,
  output logic [7:0] data_out,
  output logic       interrupt,
  input  logic       sck_i,
  input  logic       ncs_i,
  input  logic       mosi_i,
`ifdef PB_SPI_SLAVE_MISO_TRISTATE_EN
  inout  wire        miso_o
`else
  output logic       miso_o
`endif
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state;
  logic [2:0]      sck_pipe;
  logic [2:0]      ncs_pipe;
  logic [1:0]      mosi_pipe;
  logic [DW-1:0]   rx_shift;
  logic [DW-1:0]   rx_data;
  logic [DW-1:0]   tx_hold;
  logic [DW-1:0]   tx_shift;
  logic [CW-1:0]   bit_cnt;
  logic            tx_empty;
  logic            rx_valid;
  logic            overrun;
  logic            cs_done;
  logic            reload_pend;
  logic            ie_rx;
  logic            ie_cs;
  logic            miso_r;

  logic            sck_rise, sck_fall, ncs_rise, ncs_fall;
  logic [DW-1:0]   offset;
  logic            hit;
  logic            wr_data, rd_data, wr_ctrl, wr_clear;
  logic [DW-1:0]   tx_next;
  logic [DW-1:0]   rx_next;
  logic [DW-1:0]   rd_mux;

  // Two-flop synchronisers plus one history flop for edge detection; deliberately
  // not reset so a reset inside a frame cannot fabricate a chip-select edge.
  always_ff @(posedge clk) begin
    sck_pipe  <= {sck_pipe[1:0], sck_i};
    ncs_pipe  <= {ncs_pipe[1:0], ncs_i};
    mosi_pipe <= {mosi_pipe[0], mosi_i};
  end

  assign sck_rise = sck_pipe[1] & ~sck_pipe[2];
  assign sck_fall = ~sck_pipe[1] & sck_pipe[2];
  assign ncs_rise = ncs_pipe[1] & ~ncs_pipe[2];
  assign ncs_fall = ~ncs_pipe[1] & ncs_pipe[2];

  // Address decode relative to the block base.
  assign offset   = DW'(port_id - BASE_ADDRESS);
  assign hit      = (offset < DW'(4));
  assign wr_data  = write_strobe & hit & (offset[1:0] == 2'd0);
  assign rd_data  = read_strobe  & hit & (offset[1:0] == 2'd0);
  assign wr_ctrl  = write_strobe & hit & (offset[1:0] == 2'd2);
  assign wr_clear = write_strobe & hit & (offset[1:0] == 2'd3);

  assign tx_next  = tx_empty ? DW'(0) : tx_hold;
  assign rx_next  = {rx_shift[DW-2:0], mosi_pipe[1]};

  // Read-data mux; zero when the port is outside the block.
  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (offset[1:0])
        2'd0:    rd_mux = rx_data;
        2'd1:    rd_mux = {4'b0, overrun, (state == ACTIVE), tx_empty, rx_valid};
        2'd2:    rd_mux = {6'b0, ie_cs, ie_rx};
        default: rd_mux = '0;
      endcase
    end
  end

  // Register file, frame state machine and shifters; later assignments win so
  // flag sets override clears and a DATA write overrides tx_empty from a load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      data_out    <= '0;
      interrupt   <= 1'b0;
      miso_r      <= 1'b0;
      rx_shift    <= '0;
      rx_data     <= '0;
      tx_hold     <= '0;
      tx_shift    <= '0;
      bit_cnt     <= '0;
      tx_empty    <= 1'b1;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
      cs_done     <= 1'b0;
      reload_pend <= 1'b0;
      ie_rx       <= 1'b0;
      ie_cs       <= 1'b0;
    end else begin
      data_out  <= rd_mux;
      interrupt <= (ie_rx & rx_valid) | (ie_cs & cs_done);
      if (wr_ctrl) {ie_cs, ie_rx} <= data_in[1:0];
      if (wr_clear && data_in[0]) overrun <= 1'b0;
      if (wr_clear && data_in[1]) cs_done <= 1'b0;
      if (rd_data) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state       <= ACTIVE;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            tx_shift    <= tx_next;
            tx_empty    <= 1'b1;
            miso_r      <= tx_next[DW-1];
          end
        end
        ACTIVE: begin
          if (ncs_rise) begin
            state       <= IDLE;
            cs_done     <= 1'b1;
            miso_r      <= 1'b0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
          end else begin
            if (sck_rise) begin
              rx_shift <= rx_next;
              bit_cnt  <= CW'(bit_cnt + CW'(1));
              if (bit_cnt == CW'(7)) begin
                rx_data     <= rx_next;
                rx_valid    <= 1'b1;
                reload_pend <= 1'b1;
                if (rx_valid && !rd_data) overrun <= 1'b1;
              end
            end
            if (sck_fall) begin
              if (reload_pend) begin
                tx_shift    <= tx_next;
                tx_empty    <= 1'b1;
                miso_r      <= tx_next[DW-1];
                reload_pend <= 1'b0;
              end else begin
                tx_shift <= {tx_shift[DW-2:0], 1'b0};
                miso_r   <= tx_shift[DW-2];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (wr_data) begin
        tx_hold  <= data_in;
        tx_empty <= 1'b0;
      end
    end
  end

`ifdef PB_SPI_SLAVE_MISO_TRISTATE_EN
  assign miso_o = (state == ACTIVE) ? miso_r : 1'bz;
`else
  assign miso_o = miso_r;
`endif

endmodule
